// File: rtl/coreapb3_regbank_pkg.sv
// Shared types, widths and address decode for the CoreAPB3 register-bank responder.
package coreapb3_regbank_pkg;

    localparam int DATA_W  = 32;
    localparam int WAIT_CW = 4;
    localparam int IDX_W   = 6;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_e;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             is_status;
        logic             err;
    } decode_t;

    // Word offset num_regs is the read-only status word; anything past it is unmapped.
    function automatic decode_t decode_addr(input logic [31:0] addr,
                                            input int          num_regs,
                                            input logic        is_write);
        decode_t     d;
        logic [31:0] word;
        word        = {2'b00, addr[31:2]};
        d.idx       = word[IDX_W-1:0];
        d.is_status = (word == 32'(num_regs));
        d.err       = (addr[1:0] != 2'b00) || (word > 32'(num_regs)) || (is_write && d.is_status);
        return d;
    endfunction

endpackage

// File: rtl/coreapb3_regbank_responder_if.sv
// APB3 bus bundle between the CoreAPB3 bridge slot and the register-bank responder.
interface coreapb3_regbank_responder_if
    import coreapb3_regbank_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) ();

    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [DATA_W-1:0]     PWDATA;
    logic [DATA_W-1:0]     PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/coreapb3_wait_timer.sv
// Wait-state counter: loads at setup, counts down during access, flags zero.
module coreapb3_wait_timer
    import coreapb3_regbank_pkg::*;
(
    input  logic               PCLK,
    input  logic               PRESETN,
    input  logic               load_i,
    input  logic [WAIT_CW-1:0] load_val_i,
    input  logic               dec_i,
    output logic               zero_o
);

    logic [WAIT_CW-1:0] cnt_q, cnt_d;

    always_comb begin
        // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!PRESETN) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/coreapb3_regbank_responder.sv
// APB3 completer for one CoreAPB3 slot: NUM_REGS R/W registers, a status word, wait states and PSLVERR.
module coreapb3_regbank_responder
    import coreapb3_regbank_pkg::*;
#(
    parameter int                ADDR_WIDTH  = 8,
    parameter int                NUM_REGS    = 8,
    parameter int                WAIT_STATES = 2,
    parameter logic [DATA_W-1:0] RESET_VAL   = '0
) (
    input  logic                         PCLK,
    input  logic                         PRESETN,
    coreapb3_regbank_responder_if.slave  apb,
    input  logic [DATA_W-1:0]            STATUS_IN,
    output logic [DATA_W*NUM_REGS-1:0]   REGS_OUT,
    output logic [NUM_REGS-1:0]          WR_STROBE
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] paddr;
    decode_t               dec;
    logic                  setup, access_on, cnt_zero, complete, do_write;

    logic [IDX_W-1:0]      idx_q;
    logic                  write_q, err_q;
    logic [DATA_W-1:0]     wdata_q, prdata_q, rd_mux;
    logic [NUM_REGS-1:0]   wr_strobe_q, wr_strobe_d;
    logic [DATA_W-1:0]     regs_q [NUM_REGS];

    assign paddr     = apb.PADDR;
    assign dec       = decode_addr(32'(paddr), NUM_REGS, apb.PWRITE);
    assign setup     = (state_q == ST_IDLE) && apb.PSEL && !apb.PENABLE;
    assign access_on = (state_q == ST_ACCESS) && apb.PSEL && apb.PENABLE;
    assign complete  = access_on && cnt_zero;
    assign do_write  = complete && write_q && !err_q;

    coreapb3_wait_timer u_wait_timer (
        .PCLK       (PCLK),
        .PRESETN    (PRESETN),
        .load_i     (setup),
        .load_val_i (WAIT_CW'(WAIT_STATES)),
        .dec_i      (access_on),
        .zero_o     (cnt_zero)
    );

    // Dropping PSEL in ACCESS abandons the transfer without touching any register.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (setup) state_d = ST_ACCESS;
            ST_ACCESS: if (!apb.PSEL || complete) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (dec.idx == IDX_W'(i)) rd_mux = regs_q[i];
        end
        if (dec.is_status) rd_mux = STATUS_IN;
        if (apb.PWRITE || dec.err) rd_mux = '0;
    end

    always_comb begin
        wr_strobe_d = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            wr_strobe_d[i] = do_write && (idx_q == IDX_W'(i));
        end
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            write_q     <= 1'b0;
            err_q       <= 1'b0;
            wdata_q     <= '0;
            prdata_q    <= '0;
            wr_strobe_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_strobe_q <= wr_strobe_d;
            if (setup) begin
                idx_q    <= dec.idx;
                write_q  <= apb.PWRITE;
                err_q    <= dec.err;
                wdata_q  <= apb.PWDATA;
                prdata_q <= rd_mux;
            end
        end
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            // NOTE: this small register file is reset on purpose; downstream logic reads REGS_OUT directly.
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
        end else if (do_write) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (idx_q == IDX_W'(i)) regs_q[i] <= wdata_q;
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
        assign REGS_OUT[DATA_W*g +: DATA_W] = regs_q[g];
    end

    assign WR_STROBE   = wr_strobe_q;
    assign apb.PRDATA  = prdata_q;
    assign apb.PREADY  = complete;
    assign apb.PSLVERR = complete && err_q;

endmodule

// File: tb/tb_coreapb3_regbank_responder.sv
// Self-checking bench: two responders (WAIT_STATES=2 and 0) against a register-level reference model.
module tb_coreapb3_regbank_responder;

    localparam int NREG = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        psel    [2];
    logic        penable [2];
    logic        pwrite  [2];
    logic [7:0]  paddr   [2];
    logic [31:0] pwdata  [2];
    logic [31:0] status0, status1;
    logic [255:0] regs_out0, regs_out1;
    logic [7:0]  strobe0, strobe1;

    coreapb3_regbank_responder_if #(.ADDR_WIDTH(8)) bus0 ();
    coreapb3_regbank_responder_if #(.ADDR_WIDTH(8)) bus1 ();

    assign bus0.PSEL = psel[0];  assign bus0.PENABLE = penable[0];  assign bus0.PWRITE = pwrite[0];
    assign bus0.PADDR = paddr[0]; assign bus0.PWDATA = pwdata[0];
    assign bus1.PSEL = psel[1];  assign bus1.PENABLE = penable[1];  assign bus1.PWRITE = pwrite[1];
    assign bus1.PADDR = paddr[1]; assign bus1.PWDATA = pwdata[1];

    coreapb3_regbank_responder #(.ADDR_WIDTH(8), .NUM_REGS(NREG), .WAIT_STATES(2), .RESET_VAL(32'h0)) dut0 (
        .PCLK(clk), .PRESETN(rst_n), .apb(bus0), .STATUS_IN(status0), .REGS_OUT(regs_out0), .WR_STROBE(strobe0)
    );
    coreapb3_regbank_responder #(.ADDR_WIDTH(8), .NUM_REGS(NREG), .WAIT_STATES(0), .RESET_VAL(32'h0)) dut1 (
        .PCLK(clk), .PRESETN(rst_n), .apb(bus1), .STATUS_IN(status1), .REGS_OUT(regs_out1), .WR_STROBE(strobe1)
    );

    // Reference model: plain register arrays and the strobe expected on the next observed cycle.
    logic [31:0] mregs [2][NREG];
    logic [7:0]  exp_strobe [2];
    int          ws [2] = '{2, 0};
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic get_pready(input int d);
        return (d == 0) ? bus0.PREADY : bus1.PREADY;
    endfunction
    function automatic logic get_pslverr(input int d);
        return (d == 0) ? bus0.PSLVERR : bus1.PSLVERR;
    endfunction
    function automatic logic [31:0] get_prdata(input int d);
        return (d == 0) ? bus0.PRDATA : bus1.PRDATA;
    endfunction
    function automatic logic [255:0] model_flat(input int d);
        logic [255:0] f;
        for (int i = 0; i < NREG; i++) f[32*i +: 32] = mregs[d][i];
        return f;
    endfunction

    task automatic set_status(input int d, input logic [31:0] v);
        if (d == 0) status0 = v; else status1 = v;
    endtask

    task automatic reset_model();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < NREG; i++) mregs[d][i] = 32'h0;
            exp_strobe[d] = 8'h00;
        end
    endtask

    // Called at every falling edge while the bench drives traffic.
    task automatic tick_checks();
        check("regs_out0", regs_out0, model_flat(0));
        check("regs_out1", regs_out1, model_flat(1));
        check("wr_strobe0", strobe0, exp_strobe[0]);
        check("wr_strobe1", strobe1, exp_strobe[1]);
        exp_strobe[0] = 8'h00;
        exp_strobe[1] = 8'h00;
    endtask

    // Starts and ends at posedge+1; a following call therefore runs back-to-back.
    task automatic xfer(input int d, input logic wr, input logic [7:0] addr, input logic [31:0] data,
                        input logic [31:0] stat, output logic [31:0] rdata, output logic slverr);
        int          w;
        int          waits;
        bit          done;
        logic        exp_err;
        logic [31:0] exp_rd;
        w       = int'(addr >> 2);
        exp_err = (addr[1:0] != 2'b00) || (w > NREG) || (wr && (w == NREG));
        if (wr || exp_err)  exp_rd = 32'h0;
        else if (w == NREG) exp_rd = stat;
        else                exp_rd = mregs[d][w];
        rdata  = 32'h0;
        slverr = 1'b0;

        psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = addr; pwdata[d] = data;
        set_status(d, stat);
        @(negedge clk);
        tick_checks();
        check("pready_setup", get_pready(d), 1'b0);
        @(posedge clk);
        #1;
        penable[d] = 1'b1;
        paddr[d]   = 8'($urandom);
        pwdata[d]  = $urandom;
        set_status(d, $urandom);

        waits = 0;
        done  = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            tick_checks();
            if (get_pready(d)) begin
                done   = 1'b1;
                rdata  = get_prdata(d);
                slverr = get_pslverr(d);
            end else begin
                waits++;
                check("pslverr_wait", get_pslverr(d), 1'b0);
                @(posedge clk);
            end
        end
        check("pready_timeout", done, 1'b1);
        check("wait_cycles", waits, ws[d]);
        check("pslverr", slverr, exp_err);
        check("prdata", rdata, exp_rd);
        if (done && wr && !exp_err) begin
            mregs[d][w]   = data;
            exp_strobe[d] = 8'(1 << w);
        end
        @(posedge clk);
        #1;
        psel[d] = 1'b0; penable[d] = 1'b0;
    endtask

    task automatic idle(input int n, input bit junk);
        for (int k = 0; k < n; k++) begin
            // PSEL with PENABLE already high while idle must not start a transfer.
            if (junk) begin psel[0] = 1'b1; penable[0] = 1'b1; psel[1] = 1'b1; penable[1] = 1'b1; end
            @(negedge clk);
            tick_checks();
            check("pready_idle0", bus0.PREADY, 1'b0);
            check("pready_idle1", bus1.PREADY, 1'b0);
            @(posedge clk);
            #1;
            psel[0] = 1'b0; penable[0] = 1'b0; psel[1] = 1'b0; penable[1] = 1'b0;
        end
    endtask

    task automatic abort_write(input logic [7:0] addr, input logic [31:0] data);
        psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = addr; pwdata[0] = data;
        @(negedge clk);
        tick_checks();
        @(posedge clk);
        #1;
        penable[0] = 1'b1;
        @(negedge clk);
        tick_checks();
        check("abort_pready_a", bus0.PREADY, 1'b0);
        @(posedge clk);
        #1;
        psel[0] = 1'b0; penable[0] = 1'b0;
        @(negedge clk);
        tick_checks();
        check("abort_pready_b", bus0.PREADY, 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_mid_access(input logic [7:0] addr, input logic [31:0] exp_val);
        bit done;
        psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b0; paddr[0] = addr;
        @(posedge clk);
        #1;
        penable[0] = 1'b1;
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (bus0.PREADY) done = 1'b1;
            else @(posedge clk);
        end
        check("rst_pre_pready", bus0.PREADY, 1'b1);
        check("rst_pre_prdata", bus0.PRDATA, exp_val);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_async_pready", bus0.PREADY, 1'b0);
        check("rst_async_pslverr", bus0.PSLVERR, 1'b0);
        check("rst_async_prdata", bus0.PRDATA, 32'h0);
        check("rst_async_regs0", regs_out0, 256'h0);
        check("rst_async_regs1", regs_out1, 256'h0);
        check("rst_async_strobe0", strobe0, 8'h00);
        psel[0] = 1'b0; penable[0] = 1'b0;
        reset_model();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        logic        err;
        logic [31:0] v;
        logic [7:0]  a;
        int          d;
        int          r;

        for (int i = 0; i < 2; i++) begin
            psel[i] = 1'b0; penable[i] = 1'b0; pwrite[i] = 1'b0; paddr[i] = 8'h0; pwdata[i] = 32'h0;
        end
        status0 = 32'h0; status1 = 32'h0;
        reset_model();
        rst_n = 1'b0;
        #1;
        check("reset_pready0", bus0.PREADY, 1'b0);
        check("reset_pslverr0", bus0.PSLVERR, 1'b0);
        check("reset_prdata0", bus0.PRDATA, 32'h0);
        check("reset_pready1", bus1.PREADY, 1'b0);
        check("reset_regs0", regs_out0, 256'h0);
        check("reset_strobe0", strobe0, 8'h00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed: write/read, status word, error cases.
        xfer(0, 1'b1, 8'h04, 32'hA5A5_0001, 32'h0, rd, err);
        xfer(0, 1'b0, 8'h04, 32'h0, 32'h0, rd, err);
        check("dir_read04", rd, 32'hA5A5_0001);
        xfer(0, 1'b0, 8'h20, 32'h0, 32'hDEAD_BEEF, rd, err);
        check("dir_status", rd, 32'hDEAD_BEEF);
        xfer(0, 1'b1, 8'h20, 32'h1111_2222, 32'h0, rd, err);
        check("dir_err_wr20", err, 1'b1);
        xfer(0, 1'b1, 8'h24, 32'h3333_4444, 32'h0, rd, err);
        check("dir_err_wr24", err, 1'b1);
        xfer(0, 1'b0, 8'h06, 32'h0, 32'h0, rd, err);
        check("dir_err_rd06", err, 1'b1);
        check("dir_err_rd06_data", rd, 32'h0);
        idle(2, 1'b1);

        // Zero wait states, back-to-back with no idle gap.
        xfer(1, 1'b1, 8'h00, 32'hCAFE_F00D, 32'h0, rd, err);
        xfer(1, 1'b0, 8'h00, 32'h0, 32'h0, rd, err);
        check("b2b_read00", rd, 32'hCAFE_F00D);

        // Aborted write leaves reg2 untouched.
        abort_write(8'h08, 32'h0000_1234);
        idle(1, 1'b0);
        xfer(0, 1'b0, 8'h08, 32'h0, 32'h0, rd, err);
        check("abort_reg2", rd, 32'h0);

        // Reset in the completion cycle of a read.
        xfer(0, 1'b1, 8'h0C, 32'h5A5A_7777, 32'h0, rd, err);
        idle(1, 1'b0);
        reset_mid_access(8'h0C, 32'h5A5A_7777);
        xfer(0, 1'b1, 8'h0C, 32'h0BAD_CAFE, 32'h0, rd, err);
        xfer(0, 1'b0, 8'h0C, 32'h0, 32'h0, rd, err);
        check("post_reset_read", rd, 32'h0BAD_CAFE);

        // Randomized traffic on both responders.
        for (int t = 0; t < 80; t++) begin
            d = int'($urandom_range(0, 1));
            r = int'($urandom_range(0, 9));
            if (r == 9) a = 8'($urandom);
            else begin
                a = 8'(r * 4);
                if ($urandom_range(0, 5) == 0) a = a | 8'($urandom_range(1, 3));
            end
            v = $urandom;
            xfer(d, 1'($urandom_range(0, 1)), a, v, $urandom, rd, err);
            if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)), 1'($urandom_range(0, 1)));
        end
        idle(2, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
